demux1_by_8: RTL and testbench

Registered 1-to-8 demultiplexer. It is the write-side counterpart of the lab's 8:1 mux: a single data bit is routed into one of eight held channel outputs. The target channel comes from a 3-bit select (s2:s0) or from an internal auto-scan counter. The block provides a valid/ready accept handshake, per-channel write strobes, a frame-complete pulse and a synchronous clear, and sits between a serial bit source and eight parallel consumers (LEDs or mux inputs a..h).

---
 rtl/demux_pkg.sv | 20 ++
 rtl/mod8_counter.sv | 38 +++
 rtl/demux1_by_8.sv | 119 +++++++++++
 tb/tb_demux1_by_8.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-8 demultiplexer: channel geometry,
// FSM state encoding and a select-to-one-hot helper.
package demux_pkg;

   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      logic [NUM_CH-1:0] v;
      v      = {NUM_CH{1'b0}};
      v[sel] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mod8_counter.sv
// Mod-8 scan counter. A clear zeroes the base value, and an increment in the
// same cycle counts from that zeroed base, so the first scan write lands on 0.
module mod8_counter
   import demux_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [SEL_W-1:0] q,
   output logic             wrap
);

   logic [SEL_W-1:0] q_r;
   logic [SEL_W-1:0] base_s;

   // Base value the increment applies to
   always_comb begin
      if (clr) begin
         base_s = 3'd0;
      end else begin
         base_s = q_r;
      end
   end

   // Counter register; 7 + 1 wraps to 0 naturally in 3 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= 3'd0;
      end else begin
         q_r <= base_s + {2'b00, en};
      end
   end

   assign q    = q_r;
   assign wrap = en & (base_s == 3'd7);

endmodule

// File: rtl/demux1_by_8.sv
// Registered 1-to-8 demultiplexer with valid/ready accept, per-channel write
// strobes, auto-scan channel selection, frame-complete pulse and sync clear.
module demux1_by_8
   import demux_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              d,
   input  logic              s0,
   input  logic              s1,
   input  logic              s2,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              scan_en,
   input  logic              clr,
   output logic [NUM_CH-1:0] y,
   output logic [NUM_CH-1:0] strobe,
   output logic [SEL_W-1:0]  sel_q,
   output logic              frame_done
);

   state_t            state_r;
   state_t            state_nxt_s;
   logic              scan_en_d_r;
   logic [NUM_CH-1:0] y_r;
   logic [NUM_CH-1:0] strobe_r;
   logic              frame_done_r;
   logic              in_ready_s;
   logic              clr_run_s;
   logic              scan_rise_s;
   logic              accept_s;
   logic [SEL_W-1:0]  sel_s;
   logic [SEL_W-1:0]  cnt_q_s;
   logic              cnt_wrap_s;

   // FSM next state and handshake decode
   always_comb begin
      state_nxt_s = state_r;
      in_ready_s  = 1'b0;
      clr_run_s   = 1'b0;
      case (state_r)
         ST_RUN: begin
            in_ready_s = ~clr;
            if (clr) begin
               clr_run_s   = 1'b1;
               state_nxt_s = ST_CLEAR;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_CLEAR: begin
            state_nxt_s = ST_RUN;
         end
         default: begin
            state_nxt_s = ST_RUN;
         end
      endcase
   end

   // Effective channel select; a scan_en rising edge reads as channel 0
   always_comb begin
      scan_rise_s = scan_en & ~scan_en_d_r;
      if (!scan_en) begin
         sel_s = {s2, s1, s0};
      end else if (scan_rise_s) begin
         sel_s = 3'd0;
      end else begin
         sel_s = cnt_q_s;
      end
   end

   assign accept_s = in_valid & in_ready_s;

   mod8_counter u_scan_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_run_s | scan_rise_s),
      .en    (accept_s & scan_en),
      .q     (cnt_q_s),
      .wrap  (cnt_wrap_s)
   );

   // State register and scan_en edge-detect history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_RUN;
         scan_en_d_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         scan_en_d_r <= scan_en;
      end
   end

   // Channel hold registers plus the strobe/frame pulses aligned with them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_r          <= 8'h00;
         strobe_r     <= 8'h00;
         frame_done_r <= 1'b0;
      end else begin
         if (clr_run_s) begin
            y_r <= 8'h00;
         end else if (accept_s) begin
            y_r[sel_s] <= d;
         end else begin
            y_r <= y_r;
         end
         strobe_r     <= accept_s ? sel_onehot(sel_s) : 8'h00;
         frame_done_r <= cnt_wrap_s;
      end
   end

   assign in_ready   = in_ready_s;
   assign sel_q      = sel_s;
   assign y          = y_r;
   assign strobe     = strobe_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_demux1_by_8.sv
// Directed, table-driven bench for demux1_by_8 with hand sequences for clear
// collision, backpressure, scan restart and asynchronous reset.
module tb_demux1_by_8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       d, s0, s1, s2, in_valid, scan_en, clr;
   logic       in_ready, frame_done;
   logic [7:0] y, strobe;
   logic [2:0] sel_q;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   demux1_by_8 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .d          (d),
      .s0         (s0),
      .s1         (s1),
      .s2         (s2),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .scan_en    (scan_en),
      .clr        (clr),
      .y          (y),
      .strobe     (strobe),
      .sel_q      (sel_q),
      .frame_done (frame_done)
   );

   typedef struct {
      logic       d;
      logic [2:0] s;
      logic       scan;
      logic       clr;
      logic       vld;
      logic       e_rdy;
      logic [2:0] e_sel;
      logic [7:0] e_y;
      logic [7:0] e_stb;
      logic       e_fd;
   } vec_t;

   vec_t vt[21];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_sel(input logic [2:0] s);
      {s2, s1, s0} = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int pulses;

      //         d     s     scan  clr   vld   rdy   sel   y      stb    fd
      vt[0]  = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 8'h01, 1'b0};
      vt[1]  = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'h03, 8'h02, 1'b0};
      vt[2]  = '{1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 8'h07, 8'h04, 1'b0};
      vt[3]  = '{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 8'h0F, 8'h08, 1'b0};
      vt[4]  = '{1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 8'h1F, 8'h10, 1'b0};
      vt[5]  = '{1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 8'h3F, 8'h20, 1'b0};
      vt[6]  = '{1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 8'h7F, 8'h40, 1'b0};
      vt[7]  = '{1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 8'hFF, 8'h80, 1'b0};
      vt[8]  = '{1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 8'hFF, 8'h00, 1'b0};
      vt[9]  = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00, 8'h00, 1'b0};
      vt[10] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 8'h00, 1'b0};
      vt[11] = '{1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 8'h01, 1'b0};
      vt[12] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 8'h01, 8'h02, 1'b0};
      vt[13] = '{1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'h05, 8'h04, 1'b0};
      vt[14] = '{1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 8'h0D, 8'h08, 1'b0};
      vt[15] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'h0D, 8'h10, 1'b0};
      vt[16] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'h0D, 8'h20, 1'b0};
      vt[17] = '{1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 8'h4D, 8'h40, 1'b0};
      vt[18] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 8'h4D, 8'h80, 1'b1};
      vt[19] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h4C, 8'h01, 1'b0};
      vt[20] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h4C, 8'h00, 1'b0};

      rst_n = 1'b0; d = 1'b0; in_valid = 1'b0; scan_en = 1'b0; clr = 1'b0;
      set_sel(3'd5);
      #12;
      chk("reset y", y, 8'h00);
      chk("reset strobe", strobe, 8'h00);
      chk("reset frame_done", {7'd0, frame_done}, 8'h00);
      chk("reset sel_q", {5'd0, sel_q}, 8'h05);
      rst_n = 1'b1;
      #1;
      chk("reset in_ready", {7'd0, in_ready}, 8'h01);
      tick();

      for (int i = 0; i < 21; i++) begin
         d = vt[i].d; set_sel(vt[i].s); scan_en = vt[i].scan;
         clr = vt[i].clr; in_valid = vt[i].vld;
         #1;
         chk($sformatf("vec%0d in_ready", i), {7'd0, in_ready}, {7'd0, vt[i].e_rdy});
         chk($sformatf("vec%0d sel_q", i), {5'd0, sel_q}, {5'd0, vt[i].e_sel});
         tick();
         chk($sformatf("vec%0d y", i), y, vt[i].e_y);
         chk($sformatf("vec%0d strobe", i), strobe, vt[i].e_stb);
         chk($sformatf("vec%0d frame_done", i), {7'd0, frame_done}, {7'd0, vt[i].e_fd});
      end

      // Clear collision with in_valid held: accepted on the 3rd cycle
      scan_en = 1'b0; set_sel(3'd3); d = 1'b1; in_valid = 1'b1; clr = 1'b1;
      #1;
      chk("coll rdy c1", {7'd0, in_ready}, 8'h00);
      tick();
      chk("coll y c1", y, 8'h00);
      chk("coll strobe c1", strobe, 8'h00);
      clr = 1'b0;
      chk("coll rdy c2", {7'd0, in_ready}, 8'h00);
      tick();
      chk("coll y c2", y, 8'h00);
      chk("coll strobe c2", strobe, 8'h00);
      chk("coll rdy c3", {7'd0, in_ready}, 8'h01);
      tick();
      chk("coll y c3", y, 8'h08);
      chk("coll strobe c3", strobe, 8'h08);
      in_valid = 1'b0;
      tick();
      chk("coll strobe after", strobe, 8'h00);

      // Backpressure: in_valid held across CLEAR yields one write only
      set_sel(3'd5); d = 1'b1; in_valid = 1'b1; clr = 1'b1;
      tick();
      clr = 1'b0;
      n = 0;
      while (!in_ready && n < 10) begin
         tick();
         n++;
      end
      chk("bp wait cycles", n[7:0], 8'd1);
      tick();
      in_valid = 1'b0;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         if (strobe[5]) pulses++;
         tick();
      end
      chk("bp strobe count", pulses[7:0], 8'd1);
      chk("bp y", y, 8'h20);

      // Scan restart: 3 scan writes, manual write ch6, scan re-rise -> ch0
      scan_en = 1'b1; d = 1'b1; in_valid = 1'b1;
      tick(); tick(); tick();
      chk("rs y scan3", y, 8'h27);
      scan_en = 1'b0; set_sel(3'd6);
      tick();
      chk("rs y manual6", y, 8'h67);
      chk("rs strobe manual6", strobe, 8'h40);
      scan_en = 1'b1; in_valid = 1'b0;
      #1;
      chk("rs sel_q rise", {5'd0, sel_q}, 8'h00);
      tick();
      chk("rs sel_q after", {5'd0, sel_q}, 8'h00);
      d = 1'b0; in_valid = 1'b1;
      tick();
      chk("rs y ch0", y, 8'h66);
      chk("rs strobe ch0", strobe, 8'h01);
      in_valid = 1'b0;

      // Async reset mid-frame
      scan_en = 1'b0; d = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         set_sel(k[2:0]);
         tick();
      end
      chk("pre-reset y", y, 8'hFF);
      scan_en = 1'b1; d = 1'b0;
      tick(); tick(); tick(); tick();
      chk("pre-reset y scan", y, 8'hF0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst y", y, 8'h00);
      chk("async rst strobe", strobe, 8'h00);
      chk("async rst frame_done", {7'd0, frame_done}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1; d = 1'b1;
      #1;
      chk("post-rst sel_q", {5'd0, sel_q}, 8'h00);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("post-rst fd %0d", k), {7'd0, frame_done}, 8'h00);
      end
      chk("post-rst y", y, 8'h0F);
      in_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
